// File: rtl/snake_engine.sv
// Snake movement core: segment array, step timer,
// collision detect and registered cell occupancy queries.
module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 32,
  parameter int LEN_W    = 6,
  parameter int INIT_LEN = 3,
  parameter int STEP_DIV = 25000000,
  parameter int WRAP_EN  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       dir_in,
  input  logic             dir_valid,
  input  logic             grow,
  input  logic [1:0]       speed_sel,
  input  logic [XW-1:0]    query_x,
  input  logic [YW-1:0]    query_y,
  output logic             query_hit,
  output logic             query_head,
  output logic [XW-1:0]    head_x,
  output logic [YW-1:0]    head_y,
  output logic [LEN_W-1:0] length,
  output logic [1:0]       state,
  output logic             step_pulse,
  output logic             die
);

  localparam int CW = $clog2(STEP_DIV + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DEAD  = 2'd3
  } st_t;

  st_t              st_q, st_d;
  logic [XW-1:0]    seg_x [MAX_LEN];
  logic [YW-1:0]    seg_y [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic [1:0]       dir_q, pdir_q;
  logic             pgrow_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    limit;
  logic             tick;
  logic             live;
  logic             grow_ok;
  logic             grow_now;
  logic [XW-1:0]    nx;
  logic [YW-1:0]    ny;
  logic             wall;
  logic             self_hit;
  logic             move;
  logic             reload;
  logic             die_d;
  logic             qh, qhd;
  logic [1:0]       ref_dir;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_q;
  assign state  = st_q;

  assign limit    = CW'((STEP_DIV >> speed_sel) - 1);
  assign tick     = (st_q == RUN) && (cnt_q >= limit);
  assign live     = (st_q == RUN) || (st_q == PAUSE);
  assign grow_ok  = grow && live;
  assign grow_now = (pgrow_q || grow_ok) &&
                    (len_q < LEN_W'(MAX_LEN));
  // Reversal check is against the dir in force after this cycle.
  assign ref_dir  = move ? pdir_q : dir_q;

  // Candidate head one cell along the pending direction.
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    unique case (pdir_q)
      2'd0: begin
        if (seg_y[0] == '0) begin
          wall = (WRAP_EN == 0);
          ny   = YW'(GRID_H - 1);
        end else ny = seg_y[0] - 1'b1;
      end
      2'd1: begin
        if (seg_y[0] == YW'(GRID_H - 1)) begin
          wall = (WRAP_EN == 0);
          ny   = '0;
        end else ny = seg_y[0] + 1'b1;
      end
      2'd2: begin
        if (seg_x[0] == '0) begin
          wall = (WRAP_EN == 0);
          nx   = XW'(GRID_W - 1);
        end else nx = seg_x[0] - 1'b1;
      end
      2'd3: begin
        if (seg_x[0] == XW'(GRID_W - 1)) begin
          wall = (WRAP_EN == 0);
          nx   = '0;
        end else nx = seg_x[0] + 1'b1;
      end
    endcase
  end

  // Body collision; the tail vacates unless we grow.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q &&
          (grow_now || LEN_W'(i) != len_q - 1'b1) &&
          seg_x[i] == nx && seg_y[i] == ny)
        self_hit = 1'b1;
    end
  end

  // Occupancy of the display's query cell.
  always_comb begin
    qh = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q &&
          seg_x[i] == query_x && seg_y[i] == query_y)
        qh = 1'b1;
    end
    qhd = (seg_x[0] == query_x) && (seg_y[0] == query_y);
  end

  // Game state next-state and step/die decisions.
  always_comb begin
    st_d   = st_q;
    move   = 1'b0;
    reload = 1'b0;
    die_d  = 1'b0;
    unique case (st_q)
      IDLE: if (start) st_d = RUN;
      RUN: begin
        if (tick && (wall || self_hit)) begin
          st_d  = DEAD;
          die_d = 1'b1;
        end else begin
          move = tick;
          if (pause) st_d = PAUSE;
        end
      end
      PAUSE: if (!pause) st_d = RUN;
      DEAD: begin
        if (start) begin
          st_d   = RUN;
          reload = 1'b1;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Body, timer, direction, growth and query registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
      end
      len_q      <= LEN_W'(INIT_LEN);
      dir_q      <= 2'd3;
      pdir_q     <= 2'd3;
      pgrow_q    <= 1'b0;
      cnt_q      <= '0;
      step_pulse <= 1'b0;
      die        <= 1'b0;
      query_hit  <= 1'b0;
      query_head <= 1'b0;
    end else begin
      step_pulse <= move;
      die        <= die_d;
      query_hit  <= qh;
      query_head <= qhd;
      if (reload) begin
        for (int i = 0; i < INIT_LEN; i++) begin
          seg_x[i] <= XW'(GRID_W / 2 - i);
          seg_y[i] <= YW'(GRID_H / 2);
        end
        len_q   <= LEN_W'(INIT_LEN);
        dir_q   <= 2'd3;
        pdir_q  <= 2'd3;
        pgrow_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        if (st_q == RUN)
          cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (move) dir_q <= pdir_q;
        if (dir_valid && live &&
            dir_in != (ref_dir ^ 2'b01))
          pdir_q <= dir_in;
        if (tick)         pgrow_q <= 1'b0;
        else if (grow_ok) pgrow_q <= 1'b1;
        if (move) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (grow_now) len_q <= len_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: expected move/die
// events and query answers are queued, a monitor checks.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       dir_valid = 1'b0;
  logic       grow = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [5:0] qx = '0;
  logic [4:0] qy = '0;

  logic       qh0, qhd0, sp0, die0;
  logic [5:0] hx0;
  logic [4:0] hy0;
  logic [2:0] len0;
  logic [1:0] st0;
  logic       qh1, qhd1, sp1, die1;
  logic [5:0] hx1;
  logic [4:0] hy1;
  logic [2:0] len1;
  logic [1:0] st1;

  always #5 clk = ~clk;

  snake_engine #(
    .MAX_LEN(4), .LEN_W(3), .STEP_DIV(8), .WRAP_EN(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pause(pause), .dir_in(dir_in),
    .dir_valid(dir_valid), .grow(grow),
    .speed_sel(speed_sel), .query_x(qx),
    .query_y(qy), .query_hit(qh0),
    .query_head(qhd0), .head_x(hx0),
    .head_y(hy0), .length(len0), .state(st0),
    .step_pulse(sp0), .die(die0)
  );

  snake_engine #(
    .MAX_LEN(4), .LEN_W(3), .STEP_DIV(8), .WRAP_EN(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pause(pause), .dir_in(dir_in),
    .dir_valid(dir_valid), .grow(grow),
    .speed_sel(speed_sel), .query_x(qx),
    .query_y(qy), .query_hit(qh1),
    .query_head(qhd1), .head_x(hx1),
    .head_y(hy1), .length(len1), .state(st1),
    .step_pulse(sp1), .die(die1)
  );

  typedef struct {
    int k;
    int x;
    int y;
    int l;
    int s;
    int g;
  } ev_t;

  typedef struct {
    int h;
    int hd;
  } qr_t;

  ev_t q0[$];
  ev_t q1[$];
  qr_t qq[$];

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last0 = 0;
  int  last1 = 0;
  bit  en1 = 1'b0;
  bit  qv = 1'b0;
  bit  qv_d = 1'b0;

  task automatic chk(input string n, input int a,
                     input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  task automatic push(input int d, input int k,
                      input int x, input int y,
                      input int l, input int s,
                      input int g);
    ev_t e;
    e.k = k; e.x = x; e.y = y;
    e.l = l; e.s = s; e.g = g;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic cmp_ev(input string n, input ev_t e,
                        input int k, input int x,
                        input int y, input int l,
                        input int s, input int gap);
    chk({n, "_kind"}, k, e.k);
    chk({n, "_x"}, x, e.x);
    chk({n, "_y"}, y, e.y);
    chk({n, "_len"}, l, e.l);
    chk({n, "_state"}, s, e.s);
    if (e.g != 0) chk({n, "_gap"}, gap, e.g);
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    qv_d <= qv;
  end

  // Monitor: pops an expectation whenever a DUT reports.
  always @(negedge clk) begin
    ev_t e;
    qr_t r;
    if (rst_n && (sp0 || die0)) begin
      if (q0.size() == 0) begin
        chk("ev0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        cmp_ev("ev0", e, int'(die0), int'(hx0),
               int'(hy0), int'(len0), int'(st0),
               cyc - last0);
      end
      last0 = cyc;
    end
    if (rst_n && en1 && (sp1 || die1)) begin
      if (q1.size() == 0) begin
        chk("ev1_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        cmp_ev("ev1", e, int'(die1), int'(hx1),
               int'(hy1), int'(len1), int'(st1),
               cyc - last1);
      end
      last1 = cyc;
    end
    if (qv_d) begin
      if (qq.size() == 0) begin
        chk("qry_unexpected", 1, 0);
      end else begin
        r = qq.pop_front();
        chk("qry_hit", int'(qh0), r.h);
        chk("qry_head", int'(qhd0), r.hd);
      end
    end
  end

  task automatic wait_ev(input string n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sp0 || die0) got = 1'b1;
    end
    if (!got) chk({n, "_timeout"}, 0, 1);
  endtask

  task automatic wait_die(input string n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (die0) got = 1'b1;
    end
    if (!got) chk({n, "_timeout"}, 0, 1);
  endtask

  task automatic query(input int x, input int y,
                       input int h, input int hd);
    qr_t r;
    @(posedge clk); #2;
    qx = 6'(x);
    qy = 5'(y);
    qv = 1'b1;
    r.h = h;
    r.hd = hd;
    qq.push_back(r);
  endtask

  task automatic qdone();
    @(posedge clk); #2;
    qv = 1'b0;
  endtask

  task automatic set_dir(input int d);
    @(posedge clk); #2;
    dir_in = 2'(d);
    dir_valid = 1'b1;
    @(posedge clk); #2;
    dir_valid = 1'b0;
  endtask

  task automatic pulse_grow();
    @(posedge clk); #2;
    grow = 1'b1;
    @(posedge clk); #2;
    grow = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  initial begin
    // ---- phase A: movement, direction, query, pause
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hx", int'(hx0), 20);
    chk("rst_hy", int'(hy0), 15);
    chk("rst_len", int'(len0), 3);
    chk("rst_state", int'(st0), 0);
    chk("rst_qhit", int'(qh0), 0);
    chk("rst_qhead", int'(qhd0), 0);
    chk("rst_step", int'(sp0), 0);
    chk("rst_die", int'(die0), 0);
    chk("rst1_hx", int'(hx1), 20);
    chk("rst1_state", int'(st1), 0);

    push(0, 0, 21, 15, 3, 1, 0);
    push(0, 0, 22, 15, 3, 1, 8);
    push(0, 0, 23, 15, 3, 1, 8);
    push(0, 0, 23, 14, 3, 1, 8);
    push(0, 0, 23, 13, 3, 1, 8);
    push(0, 0, 23, 12, 3, 1, 8);
    push(0, 0, 23, 11, 3, 1, 28);

    set_dir(0);
    pulse_grow();
    pulse_start();
    @(negedge clk);
    chk("run_state", int'(st0), 1);
    wait_ev("a1");
    wait_ev("a2");
    set_dir(2);
    wait_ev("a3");
    set_dir(0);
    wait_ev("a4");
    wait_ev("a5");
    query(23, 15, 1, 0);
    query(23, 13, 1, 1);
    query(22, 15, 0, 0);
    qdone();
    wait_ev("a6");
    @(posedge clk); #2;
    pause = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pause_state", int'(st0), 2);
    repeat (10) @(posedge clk);
    #2 pause = 1'b0;
    wait_ev("a7");

    // ---- phase B: growth, wall die vs wrap, restart
    @(posedge clk); #2;
    rst_n = 1'b0;
    speed_sel = 2'd1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    en1 = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      push(0, 0, 20 + k, 15, 4, 1, (k == 1) ? 0 : 4);
      push(1, 0, 20 + k, 15, 4, 1, (k == 1) ? 0 : 4);
    end
    push(0, 1, 39, 15, 4, 3, 4);
    push(1, 0, 0, 15, 4, 1, 4);
    push(0, 0, 21, 15, 3, 1, 0);

    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 grow = 1'b1;
    @(posedge clk); #2;
    grow = 1'b0;
    wait_ev("b1");
    wait_ev("b2");
    pulse_grow();
    @(posedge clk); #2;
    grow = 1'b1;
    @(posedge clk); #2;
    grow = 1'b0;
    wait_die("b_die");
    @(posedge clk);
    en1 = 1'b0;
    chk("q1_drained", q1.size(), 0);
    @(negedge clk);
    chk("dead_hx", int'(hx0), 39);
    chk("dead_state", int'(st0), 3);
    chk("dead_die", int'(die0), 0);
    chk("wrap_hx", int'(hx1), 0);
    chk("wrap_state", int'(st1), 1);
    query(38, 15, 1, 0);
    query(39, 15, 1, 1);
    query(36, 15, 1, 0);
    query(35, 15, 0, 0);
    qdone();
    pulse_start();
    @(negedge clk);
    chk("restart_state", int'(st0), 1);
    chk("restart_hx", int'(hx0), 20);
    chk("restart_hy", int'(hy0), 15);
    chk("restart_len", int'(len0), 3);
    wait_ev("b_restart");
    repeat (2) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("qq_empty", qq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
